ram_dump: RTL and testbench

UART memory-dump engine: reads a block of 32-bit words from RAM through the data read port and streams them out, byte by byte, on the AXI-stream output that feeds the UART transmitter. It is the reverse path of the BIOS UART loader, which writes incoming bytes into RAM. It lets the host read back loaded images or post-`ebreak` memory state. It shares the RAM data-read port and the UART TX stream through the same boot-time muxing the loader uses.

---
 rtl/ram_dump.sv | 182 ++++++++++++++++++
 tb/tb_ram_dump.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dump.sv
// UART memory-dump engine: reads a block of RAM words and streams them out
// little-endian on a byte-wide valid/ready port, optionally followed by a checksum byte.
module ram_dump #(
    parameter int ADDR_WIDTH    = 32,
    parameter int COUNT_WIDTH   = 16,
    parameter bit SEND_CHECKSUM = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clk_en,
    input  logic                   i_start,
    input  logic [ADDR_WIDTH-1:0]  i_base_addr,
    input  logic [COUNT_WIDTH-1:0] i_word_count,
    output logic                   o_read_req,
    output logic [ADDR_WIDTH-1:0]  o_read_addr,
    input  logic [31:0]            i_read_data,
    output logic [7:0]             o_data,
    output logic                   o_valid,
    input  logic                   i_out_ready,
    output logic                   o_busy,
    output logic                   o_done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_LATCH  = 3'd2,
        ST_SEND   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

    localparam logic [ADDR_WIDTH-1:0]  WORD_STEP = ADDR_WIDTH'(3'd4);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1'b1);

    function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] data_byte);
        return sum + data_byte;
    endfunction

    // Negated running sum, so data bytes plus this byte total 0x00 modulo 256.
    function automatic logic [7:0] csum_final(input logic [7:0] sum);
        return 8'h00 - sum;
    endfunction

    state_t                   state_r;
    logic [ADDR_WIDTH-1:0]    addr_r;
    logic [COUNT_WIDTH-1:0]   remaining_r;
    logic [23:0]              shift_r;
    logic [1:0]               byte_idx_r;
    logic [7:0]               sum_r;
    logic                     read_req_r;
    logic [ADDR_WIDTH-1:0]    read_addr_r;
    logic [7:0]               data_r;
    logic                     valid_r;
    logic                     busy_r;
    logic                     done_r;

    logic                     handshake_s;
    logic [7:0]               sum_next_s;
    logic [ADDR_WIDTH-1:0]    aligned_base_s;
    logic                     unused_s;

    // Handshake and next-checksum decode from registered state only.
    always_comb begin
        handshake_s    = valid_r & i_out_ready;
        sum_next_s     = csum_add(sum_r, data_r);
        aligned_base_s = {i_base_addr[ADDR_WIDTH-1:2], 2'b00};
    end

    assign unused_s = ^i_base_addr[1:0];

    // Sequencer: FSM state, datapath registers and every registered output.
    // data_r always carries the current byte; shift_r holds the bytes still to go.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            addr_r      <= '0;
            remaining_r <= '0;
            shift_r     <= 24'h00_0000;
            byte_idx_r  <= 2'd0;
            sum_r       <= 8'h00;
            read_req_r  <= 1'b0;
            read_addr_r <= '0;
            data_r      <= 8'h00;
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else if (clk_en) begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (i_start) begin
                        addr_r      <= aligned_base_s;
                        remaining_r <= i_word_count;
                        sum_r       <= 8'h00;
                        busy_r      <= 1'b1;
                        if (|i_word_count) begin
                            state_r     <= ST_READ;
                            read_req_r  <= 1'b1;
                            read_addr_r <= aligned_base_s;
                        end else if (SEND_CHECKSUM) begin
                            state_r <= ST_CSUM;
                            valid_r <= 1'b1;
                            data_r  <= csum_final(8'h00);
                        end else begin
                            state_r <= ST_FINISH;
                            done_r  <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    read_req_r <= 1'b0;
                    state_r    <= ST_LATCH;
                end
                ST_LATCH: begin
                    shift_r     <= i_read_data[31:8];
                    data_r      <= i_read_data[7:0];
                    valid_r     <= 1'b1;
                    byte_idx_r  <= 2'd0;
                    addr_r      <= addr_r + WORD_STEP;
                    remaining_r <= remaining_r - COUNT_ONE;
                    state_r     <= ST_SEND;
                end
                ST_SEND: begin
                    if (handshake_s) begin
                        sum_r      <= sum_next_s;
                        byte_idx_r <= byte_idx_r + 2'd1;
                        if (byte_idx_r == 2'd3) begin
                            if (|remaining_r) begin
                                state_r     <= ST_READ;
                                valid_r     <= 1'b0;
                                data_r      <= 8'h00;
                                read_req_r  <= 1'b1;
                                read_addr_r <= addr_r;
                            end else if (SEND_CHECKSUM) begin
                                state_r <= ST_CSUM;
                                data_r  <= csum_final(sum_next_s);
                            end else begin
                                state_r <= ST_FINISH;
                                valid_r <= 1'b0;
                                data_r  <= 8'h00;
                                done_r  <= 1'b1;
                            end
                        end else begin
                            shift_r <= {8'h00, shift_r[23:8]};
                            data_r  <= shift_r[7:0];
                        end
                    end
                end
                ST_CSUM: begin
                    if (handshake_s) begin
                        state_r <= ST_FINISH;
                        valid_r <= 1'b0;
                        data_r  <= 8'h00;
                        done_r  <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    read_req_r <= 1'b0;
                    valid_r    <= 1'b0;
                    data_r     <= 8'h00;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                end
            endcase
        end
    end

    assign o_read_req  = read_req_r;
    assign o_read_addr = read_addr_r;
    assign o_data      = data_r;
    assign o_valid     = valid_r;
    assign o_busy      = busy_r;
    assign o_done      = done_r;

endmodule

// File: tb/tb_ram_dump.sv
// Randomized bench for ram_dump: a RAM model feeds the DUT and a queue-based
// reference model predicts read addresses, stream bytes and completion timing.
module tb_ram_dump;

    localparam int AW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clk_en = 1'b1;
    logic          out_ready = 1'b1;
    logic          start = 1'b0;
    logic          start_b = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] word_count = '0;
    logic [31:0]   read_data = 32'h0;
    logic          read_req, valid, busy, done;
    logic [AW-1:0] read_addr;
    logic [7:0]    data;
    logic          b_read_req, b_valid, b_busy, b_done;
    logic [AW-1:0] b_read_addr;
    logic [7:0]    b_data;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int rd_cnt = 0;
    bit rand_ready = 1'b0;
    bit rand_en = 1'b0;
    bit en_low = 1'b0;
    logic       pv_valid = 1'b0;
    logic       pv_hs = 1'b0;
    logic [7:0] pv_data = 8'h00;

    logic [31:0] mem [logic [31:0]];
    logic [7:0]  exp_bytes [$];
    logic [31:0] exp_addrs [$];

    ram_dump #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CW), .SEND_CHECKSUM(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .i_start(start),
        .i_base_addr(base_addr), .i_word_count(word_count),
        .o_read_req(read_req), .o_read_addr(read_addr), .i_read_data(read_data),
        .o_data(data), .o_valid(valid), .i_out_ready(out_ready),
        .o_busy(busy), .o_done(done)
    );

    ram_dump #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CW), .SEND_CHECKSUM(1'b0)) dut_nocsum (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .i_start(start_b),
        .i_base_addr(base_addr), .i_word_count(word_count),
        .o_read_req(b_read_req), .o_read_addr(b_read_addr), .i_read_data(read_data),
        .o_data(b_data), .o_valid(b_valid), .i_out_ready(out_ready),
        .o_busy(b_busy), .o_done(b_done)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Synchronous RAM: data appears the cycle after the request.
    always @(posedge clk) if (read_req) read_data <= ram_word(read_addr);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: addresses and bytes a dump of this block should produce.
    task automatic expect_dump(input logic [31:0] base, input int count);
        logic [31:0] a;
        logic [31:0] w;
        logic [7:0]  sum;
        sum = 8'h00;
        for (int i = 0; i < count; i++) begin
            a = {base[31:2], 2'b00} + 32'(4 * i);
            exp_addrs.push_back(a);
            w = ram_word(a);
            for (int b = 0; b < 4; b++) begin
                exp_bytes.push_back(w[8*b +: 8]);
                sum = sum + w[8*b +: 8];
            end
        end
        exp_bytes.push_back(8'h00 - sum);
    endtask

    // Input driver for ready and clock-enable.
    initial forever begin
        @(posedge clk);
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rand_en) clk_en = ($urandom_range(0, 3) != 0);
        else         clk_en = !en_low;
    end

    // Monitor: everything observed here is what the next rising edge consumes.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            pv_valid = 1'b0;
            pv_hs    = 1'b0;
        end else begin
            if (pv_valid && !pv_hs)
                check_eq("hold_stable", {23'd0, valid, data}, {23'd0, 1'b1, pv_data});
            if (valid && out_ready && clk_en) begin
                if (exp_bytes.size() == 0) check_eq("byte_underrun", 32'(exp_bytes.size()), 32'd1);
                else check_eq("byte", {24'd0, data}, {24'd0, exp_bytes.pop_front()});
            end
            if (read_req && clk_en) begin
                rd_cnt++;
                if (exp_addrs.size() == 0) check_eq("read_underrun", 32'(exp_addrs.size()), 32'd1);
                else check_eq("read_addr", read_addr, exp_addrs.pop_front());
            end
            if (done && clk_en) begin
                done_cnt++;
                done_cyc = cyc;
            end
            pv_valid = valid;
            pv_data  = data;
            pv_hs    = valid && out_ready && clk_en;
        end
    end

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_read_req"},  {31'd0, read_req}, 32'd0);
        check_eq({tag, "_read_addr"}, read_addr, 32'd0);
        check_eq({tag, "_data"},      {24'd0, data}, 32'd0);
        check_eq({tag, "_valid"},     {31'd0, valid}, 32'd0);
        check_eq({tag, "_busy"},      {31'd0, busy}, 32'd0);
        check_eq({tag, "_done"},      {31'd0, done}, 32'd0);
    endtask

    task automatic start_dump(input logic [31:0] base, input int count, output int s_cyc);
        expect_dump(base, count);
        base_addr  = base;
        word_count = CW'(count);
        start      = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (clk_en) break;
        end
        @(posedge clk);
        #1;
        start      = 1'b0;
        s_cyc      = cyc;
        base_addr  = $urandom;
        word_count = CW'($urandom);
        check_eq("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    // Latency is the spec's cycle number of o_done, counting the cycle after the start edge as 1.
    task automatic wait_done(input int s_cyc, output int lat);
        int d0;
        d0  = done_cnt;
        lat = -1;
        for (int k = 0; k < 3000 && done_cnt == d0; k++) @(posedge clk);
        if (done_cnt == d0) begin
            check_eq("done_timeout", done_cnt, d0 + 1);
        end else begin
            #1;
            lat = done_cyc - s_cyc + 1;
            check_eq("idle_busy", {31'd0, busy}, 32'd0);
            check_eq("idle_done", {31'd0, done}, 32'd0);
            check_eq("bytes_left", 32'(exp_bytes.size()), 32'd0);
            check_eq("reads_left", 32'(exp_addrs.size()), 32'd0);
        end
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 200 && !valid; i++) @(negedge clk);
        check_eq("wait_valid", {31'd0, valid}, 32'd1);
    endtask

    initial begin
        int s, lat, b_lat, b_cnt, rd0, d0;
        logic [31:0] rb;
        int rc;

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single word, ready high: bytes 11 22 33 44 then 56, done in cycle 8.
        mem[32'h100] = 32'h4433_2211;
        start_dump(32'h100, 1, s);
        wait_done(s, lat);
        check_eq("lat_single", lat, 8);

        // Two words under pseudo-random backpressure; checksum comes out 0x00.
        mem[32'h200] = 32'h0000_00FF;
        mem[32'h204] = 32'h0100_0000;
        rand_ready = 1'b1;
        start_dump(32'h200, 2, s);
        wait_done(s, lat);
        rand_ready = 1'b0;

        // Zero words with checksum: lone 0x00 byte, no reads.
        start_dump(32'h0, 0, s);
        wait_done(s, lat);
        check_eq("lat_zero_csum", lat, 2);

        // Zero words without checksum: no bytes, no reads, a single done pulse.
        base_addr  = 32'h40;
        word_count = '0;
        start_b    = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        b_lat   = 0;
        b_cnt   = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check_eq("b_no_stream", {30'd0, b_valid, b_read_req}, 32'd0);
            if (b_done) begin
                b_cnt++;
                b_lat = i;
            end
        end
        check_eq("b_done_pulses", b_cnt, 1);
        check_eq("b_done_by_cycle2", {31'd0, (b_lat >= 1 && b_lat <= 2)}, 32'd1);
        check_eq("b_idle_busy", {31'd0, b_busy}, 32'd0);
        @(posedge clk);
        #1;

        // Unaligned base at the top of the address space wraps to zero.
        start_dump(32'hFFFF_FFFE, 2, s);
        wait_done(s, lat);
        check_eq("lat_wrap", lat, 14);

        // A start pulse mid-dump must be ignored.
        rand_ready = 1'b1;
        start_dump(32'h0000_3001, 3, s);
        wait_valid();
        @(posedge clk);
        #1;
        base_addr  = 32'h0000_5000;
        word_count = CW'(7);
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(s, lat);
        rand_ready = 1'b0;

        // Five disabled edges mid-SEND delay completion by exactly five cycles.
        start_dump(32'h400, 2, s);
        wait_valid();
        en_low = 1'b1;
        repeat (5) @(negedge clk);
        en_low = 1'b0;
        wait_done(s, lat);
        check_eq("lat_clk_en", lat, 19);

        // Asynchronous reset during word 3 of 8 aborts without done.
        rd0 = rd_cnt;
        start_dump(32'h800, 8, s);
        for (int i = 0; i < 500 && rd_cnt < rd0 + 3; i++) @(negedge clk);
        check_eq("word3_reached", {31'd0, (rd_cnt >= rd0 + 3)}, 32'd1);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("abort");
        exp_bytes.delete();
        exp_addrs.delete();
        d0 = done_cnt;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("no_done_after_abort", done_cnt, d0);
        mem[32'h900] = 32'hC0DE_1234;
        start_dump(32'h900, 1, s);
        wait_done(s, lat);
        check_eq("lat_after_reset", lat, 8);

        // Random blocks with random backpressure and clock-enable gaps.
        rand_ready = 1'b1;
        rand_en    = 1'b1;
        for (int t = 0; t < 8; t++) begin
            rb = $urandom;
            rc = $urandom_range(0, 4);
            for (int i = 0; i < rc; i++) mem[{rb[31:2], 2'b00} + 32'(4 * i)] = $urandom;
            start_dump(rb, rc, s);
            wait_done(s, lat);
        end
        rand_en    = 1'b0;
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
